// File: rtl/capture_seq_ctrl.sv
// Triggered circular capture sequencer: port A fills a pre/post-trigger ring in the sample
// buffer, port B streams the captured frame back in chronological order over valid/ready.
module capture_seq_ctrl #(
   parameter int ADDR_WIDTH = 13,
   parameter int DATA_WIDTH = 11,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  arm,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] pretrig_len,
   input  logic [DATA_WIDTH-1:0] sample_in,
   input  logic                  sample_valid,
   input  logic                  trig_in,
   output logic [ADDR_WIDTH-1:0] ram_a_addr,
   output logic [DATA_WIDTH-1:0] ram_a_wr_data,
   output logic                  ram_a_wr_en,
   output logic [ADDR_WIDTH-1:0] ram_b_addr,
   input  logic [DATA_WIDTH-1:0] ram_b_rd_data,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] trig_addr,
   output logic                  done
);

   localparam int                  DEPTH       = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] FRAME_WORDS = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] LAST_WORD   = (ADDR_WIDTH + 1)'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] MAX_PRE   = '1;

   typedef enum logic [2:0] {IDLE, PREFILL, WAIT_TRIG, POSTFILL, READOUT} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] pre_len;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] pre_cnt;
   logic [ADDR_WIDTH-1:0] post_cnt;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   rd_cnt;
   logic [RD_LATENCY-1:0] rd_pipe_vld;
   logic [RD_LATENCY-1:0] rd_pipe_last;
   logic [DATA_WIDTH-1:0] skid_data;
   logic                  skid_valid;
   logic                  skid_last;

   logic       accept;
   logic       pop;
   logic       push;
   logic       push_last;
   logic       rd_issue;
   logic       rd_issue_last;
   logic [7:0] inflight;
   logic [7:0] committed;

   assign busy       = (state != IDLE);
   assign ram_b_addr = rd_ptr;
   assign accept     = sample_valid && !abort &&
                       (state inside {PREFILL, WAIT_TRIG, POSTFILL});
   assign pop        = out_valid && out_ready;
   assign push       = rd_pipe_vld[RD_LATENCY-1];
   assign push_last  = rd_pipe_last[RD_LATENCY-1];

   // Credit check counts the head word leaving this cycle, so the skid pair sustains 1 word/clk.
   always_comb begin
      // NOTE: combinational logic uses blocking assignments and sets every output first, so no latch is inferred.
      inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         inflight = inflight + 8'(rd_pipe_vld[i]);
      end
      committed     = 8'(out_valid) + 8'(skid_valid) + inflight;
      rd_issue      = (state == READOUT) && !abort && (rd_cnt != FRAME_WORDS) &&
                      (committed < (pop ? 8'd3 : 8'd2));
      rd_issue_last = rd_issue && (rd_cnt == LAST_WORD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         pre_len       <= '0;
         wr_ptr        <= '0;
         pre_cnt       <= '0;
         post_cnt      <= '0;
         rd_ptr        <= '0;
         rd_cnt        <= '0;
         rd_pipe_vld   <= '0;
         rd_pipe_last  <= '0;
         skid_data     <= '0;
         skid_valid    <= 1'b0;
         skid_last     <= 1'b0;
         ram_a_addr    <= '0;
         ram_a_wr_data <= '0;
         ram_a_wr_en   <= 1'b0;
         out_data      <= '0;
         out_valid     <= 1'b0;
         out_last      <= 1'b0;
         trig_addr     <= '0;
         done          <= 1'b0;
      end else begin
         done        <= 1'b0;
         ram_a_wr_en <= accept;
         if (accept) begin
            ram_a_addr    <= wr_ptr;
            ram_a_wr_data <= sample_in;
            wr_ptr        <= wr_ptr + 1'b1;
         end

         // Read tags travel alongside the RAM latency so returning data knows if it is real/last.
         for (int i = RD_LATENCY - 1; i > 0; i--) begin
            rd_pipe_vld[i]  <= rd_pipe_vld[i-1];
            rd_pipe_last[i] <= rd_pipe_last[i-1];
         end
         rd_pipe_vld[0]  <= rd_issue;
         rd_pipe_last[0] <= rd_issue_last;
         if (rd_issue) begin
            rd_ptr <= rd_ptr + 1'b1;
            rd_cnt <= rd_cnt + 1'b1;
         end

         if (!out_valid || pop) begin
            if (skid_valid) begin
               out_data   <= skid_data;
               out_last   <= skid_last;
               out_valid  <= 1'b1;
               skid_valid <= push;
               skid_data  <= ram_b_rd_data;
               skid_last  <= push_last;
            end else begin
               out_valid <= push;
               out_data  <= ram_b_rd_data;
               out_last  <= push_last;
            end
         end else if (push) begin
            skid_valid <= 1'b1;
            skid_data  <= ram_b_rd_data;
            skid_last  <= push_last;
         end

         // NOTE: within one clocked block the last non-blocking assignment wins, so abort overrides the updates above.
         if (abort) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            skid_valid  <= 1'b0;
            rd_pipe_vld <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (arm) begin
                     pre_len <= pretrig_len;
                     wr_ptr  <= '0;
                     pre_cnt <= '0;
                     rd_cnt  <= '0;
                     state   <= (pretrig_len == '0) ? WAIT_TRIG : PREFILL;
                  end
               end
               PREFILL: begin
                  if (sample_valid) begin
                     pre_cnt <= pre_cnt + 1'b1;
                     if (pre_cnt == pre_len - 1'b1) state <= WAIT_TRIG;
                  end
               end
               WAIT_TRIG: begin
                  if (sample_valid && trig_in) begin
                     trig_addr <= wr_ptr;
                     post_cnt  <= ~pre_len;
                     if (pre_len == MAX_PRE) begin
                        rd_ptr <= wr_ptr - pre_len;
                        state  <= READOUT;
                     end else begin
                        state <= POSTFILL;
                     end
                  end
               end
               POSTFILL: begin
                  if (sample_valid) begin
                     post_cnt <= post_cnt - 1'b1;
                     if (post_cnt == ADDR_WIDTH'(1)) begin
                        rd_ptr <= trig_addr - pre_len;
                        state  <= READOUT;
                     end
                  end
               end
               READOUT: begin
                  if (pop && out_last) begin
                     done  <= 1'b1;
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_capture_seq_ctrl.sv
// Scoreboard bench for capture_seq_ctrl on a 16-deep buffer with a 1-clock-latency RAM model.
module tb_capture_seq_ctrl;

   localparam int AW    = 4;
   localparam int DW    = 11;
   localparam int DEPTH = 2 ** AW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          arm = 1'b0;
   logic          abort = 1'b0;
   logic [AW-1:0] pretrig_len = '0;
   logic [DW-1:0] sample_in = '0;
   logic          sample_valid = 1'b0;
   logic          trig_in = 1'b0;
   logic [AW-1:0] ram_a_addr;
   logic [DW-1:0] ram_a_wr_data;
   logic          ram_a_wr_en;
   logic [AW-1:0] ram_b_addr;
   logic [DW-1:0] ram_b_rd_data;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic          out_last;
   logic          busy;
   logic [AW-1:0] trig_addr;
   logic          done;

   always #5 clk = ~clk;

   capture_seq_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) dut (
      .clk(clk), .rst(rst), .arm(arm), .abort(abort), .pretrig_len(pretrig_len),
      .sample_in(sample_in), .sample_valid(sample_valid), .trig_in(trig_in),
      .ram_a_addr(ram_a_addr), .ram_a_wr_data(ram_a_wr_data), .ram_a_wr_en(ram_a_wr_en),
      .ram_b_addr(ram_b_addr), .ram_b_rd_data(ram_b_rd_data),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .busy(busy), .trig_addr(trig_addr), .done(done)
   );

   // Dual-port sample buffer, registered read port.
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (ram_a_wr_en) mem[ram_a_addr] <= ram_a_wr_data;
      ram_b_rd_data <= mem[ram_b_addr];
   end

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   bit   rand_ready = 1'b0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] outs_vec();
      return 64'({ram_a_addr, ram_a_wr_data, ram_a_wr_en, ram_b_addr, out_data,
                  out_valid, out_last, busy, trig_addr, done});
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         #1;
         out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Scoreboard: every accepted word is popped against the frame predicted at trigger time.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         check("word_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_data", 64'(out_data), 64'(e.data));
            check("out_last", 64'(out_last), 64'(e.last));
         end
      end
   end

   task automatic run_capture(input int pre, input int base, input int trig_idx,
                              input int ghost_idx, input bit rmode, input int abort_after);
      int idx;
      int last_idx;
      bit v;
      bit seen;
      exp_q.delete();
      rand_ready = rmode;
      @(posedge clk);
      #1;
      arm          = 1'b1;
      pretrig_len  = AW'(pre);
      sample_valid = 1'b0;
      trig_in      = 1'b0;
      @(posedge clk);
      #1;
      arm         = 1'b0;
      pretrig_len = AW'(~pre);
      idx      = 0;
      last_idx = trig_idx + DEPTH - pre - 1;
      while (idx <= last_idx) begin
         v            = rmode ? ($urandom_range(0, 3) != 0) : 1'b1;
         sample_valid = v;
         sample_in    = DW'(base + idx);
         trig_in      = v ? ((idx == trig_idx) || (idx == ghost_idx)) : rmode;
         arm          = v && (idx == 2);
         if (v && idx == trig_idx) begin
            for (int k = 0; k < DEPTH; k++)
               exp_q.push_back('{data: DW'(base + trig_idx - pre + k), last: (k == DEPTH - 1)});
         end
         if (v && abort_after >= 0 && idx == trig_idx + abort_after) begin
            abort = 1'b1;
            @(posedge clk);
            #1;
            abort        = 1'b0;
            sample_valid = 1'b0;
            trig_in      = 1'b0;
            arm          = 1'b0;
            exp_q.delete();
            @(negedge clk);
            check("abort_busy", 64'(busy), 64'd0);
            check("abort_valid", 64'(out_valid), 64'd0);
            check("abort_wr_en", 64'(ram_a_wr_en), 64'd0);
            check("abort_trig_addr", 64'(trig_addr), 64'(trig_idx % DEPTH));
            seen = 1'b0;
            for (int n = 0; n < 20; n++) begin
               @(negedge clk);
               if (out_valid || busy || done) seen = 1'b1;
            end
            check("abort_quiet", 64'(seen), 64'd0);
            return;
         end
         @(posedge clk);
         #1;
         if (v) idx++;
      end
      sample_valid = 1'b0;
      trig_in      = 1'b0;
      arm          = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("first_valid_early", 64'(out_valid), 64'd0);
      @(negedge clk);
      check("first_valid_latency", 64'(out_valid), 64'd1);
      if (!rmode) begin
         for (int k = 1; k < DEPTH; k++) begin
            @(negedge clk);
            check("stream_gapless", 64'(out_valid), 64'd1);
         end
         @(negedge clk);
         check("done_pulse", 64'(done), 64'd1);
         check("busy_after_done", 64'(busy), 64'd0);
         @(negedge clk);
         check("done_one_cycle", 64'(done), 64'd0);
      end else begin
         seen = 1'b0;
         for (int n = 0; n < 600 && !seen; n++) begin
            @(negedge clk);
            seen = done;
         end
         check("done_seen", 64'(seen), 64'd1);
         check("busy_after_done", 64'(busy), 64'd0);
      end
      check("frame_drained", 64'(exp_q.size()), 64'd0);
      check("trig_addr", 64'(trig_addr), 64'(trig_idx % DEPTH));
      check("idle_valid", 64'(out_valid), 64'd0);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         arm          = ~arm;
         sample_valid = ~sample_valid;
         trig_in      = ~trig_in;
         sample_in    = DW'(i + 7);
         @(negedge clk);
         check("reset_outputs", outs_vec(), 64'd0);
      end
      rst          = 1'b0;
      arm          = 1'b0;
      sample_valid = 1'b0;
      trig_in      = 1'b0;
      @(negedge clk);
      check("post_reset_busy", 64'(busy), 64'd0);
      check("post_reset_wr_en", 64'(ram_a_wr_en), 64'd0);

      run_capture(4, 0, 20, -1, 1'b0, -1);
      run_capture(0, 5, 0, -1, 1'b0, -1);
      run_capture(15, 0, 40, -1, 1'b0, -1);
      run_capture(4, 0, 20, -1, 1'b1, -1);
      run_capture(4, 200, 7, 3, 1'b0, -1);
      run_capture(4, 100, 20, -1, 1'b0, 3);
      run_capture(4, 300, 20, -1, 1'b0, -1);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/capture_seq_ctrl.md
Name: capture_seq_ctrl

Overview:
- Sequences the 8192-deep dual-port sample buffer as a triggered circular capture memory.
- Port A side: writes incoming ADC samples continuously into a ring, keeping a programmable pre-trigger history, then completes the post-trigger fill.
- Port B side: reads the frame back in chronological order as a valid/ready stream for the upload/display path.
- Single clock domain; both RAM ports are driven from clk.

Parameters:
ADDR_WIDTH, 13, RAM address width; DEPTH = 2**ADDR_WIDTH
DATA_WIDTH, 11, sample width
RD_LATENCY, 1, port B read latency in clocks (RAM output register off)

Ports:
clk  input  1  system clock; RAM a_clk and b_clk are tied to it
rst  input  1  synchronous, active-high reset
arm  input  1  pulse; starts a capture from IDLE
abort  input  1  pulse; returns to IDLE from any state
pretrig_len  input  ADDR_WIDTH  pre-trigger sample count, 0..DEPTH-1, latched on arm
sample_in  input  DATA_WIDTH  ADC sample
sample_valid  input  1  sample_in qualifier
trig_in  input  1  trigger; sampled only when sample_valid=1
ram_a_addr  output  ADDR_WIDTH  port A address
ram_a_wr_data  output  DATA_WIDTH  port A write data
ram_a_wr_en  output  1  port A write enable
ram_b_addr  output  ADDR_WIDTH  port B address
ram_b_rd_data  input  DATA_WIDTH  port B read data
out_data  output  DATA_WIDTH  readout word
out_valid  output  1  readout handshake valid
out_ready  input  1  readout handshake ready
out_last  output  1  marks word DEPTH of the frame
busy  output  1  high in every state except IDLE
trig_addr  output  ADDR_WIDTH  RAM address of the trigger sample, held until next arm
done  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset: state IDLE. All outputs 0: ram_a_*, ram_b_addr, out_*, busy, trig_addr, done. Internal pointers and counters 0.
- States: IDLE, PREFILL, WAIT_TRIG, POSTFILL, READOUT.
- IDLE
  - arm=1: latch pre_len=pretrig_len; wr_ptr=0.
  - Next state is PREFILL, or WAIT_TRIG if pre_len=0.
  - arm is ignored in all other states.
- Write path (PREFILL, WAIT_TRIG, POSTFILL only)
  - Each sample_valid=1 cycle registers ram_a_addr=wr_ptr, ram_a_wr_data=sample_in, ram_a_wr_en=1 on the next clock.
  - wr_ptr increments modulo DEPTH, wrapping DEPTH-1 -> 0.
  - ram_a_wr_en=0 in any cycle without an accepted sample and in IDLE/READOUT.
- PREFILL
  - Counts accepted samples; trig_in is ignored.
  - When the count reaches pre_len (the accepted sample completing the count), go to WAIT_TRIG.
- WAIT_TRIG
  - Ring writing continues; overwriting the oldest data is expected.
  - First sample with trig_in=1 and sample_valid=1 is the trigger sample: it is written, trig_addr<=wr_ptr, post_cnt<=DEPTH-pre_len-1.
  - Next state: POSTFILL, or READOUT if post_cnt=0.
- POSTFILL
  - Each accepted sample decrements post_cnt.
  - The sample that takes post_cnt to 0 is the last one written; go to READOUT next cycle.
  - Total frame = pre_len samples before the trigger + trigger + DEPTH-pre_len-1 after = DEPTH.
- READOUT
  - rd_ptr starts at (trig_addr - pre_len) mod DEPTH; DEPTH reads are issued, rd_ptr incrementing modulo DEPTH.
  - Frame word index pre_len is the trigger sample.
  - Read data returns RD_LATENCY clocks after ram_b_addr is presented; it is captured into a 2-entry output skid FIFO.
  - A read is issued only when FIFO occupancy + reads in flight < 2. No word is lost or duplicated under any out_ready pattern.
  - With out_ready held at 1: first out_valid is 2 clocks after READOUT entry; throughput is 1 word/clk thereafter.
  - out_data and out_valid are held stable while out_valid=1 and out_ready=0.
  - out_last=1 only with word DEPTH.
  - On acceptance of the last word: done=1 for one cycle, then IDLE.
- abort=1 (any state)
  - Next cycle: IDLE; ram_a_wr_en=0; out_valid=0; FIFO flushed; in-flight reads discarded; done not asserted.
  - trig_addr is retained.
- Simultaneous events
  - abort wins over arm, trig_in and the last-word handshake.
  - A trigger on the cycle PREFILL completes is ignored.
  - rst has priority over everything.

Test Plan:
- Reset: rst=1 for 3 clk with arm, sample_valid and trig_in toggling -> all outputs 0, no RAM writes.
- ADDR_WIDTH=4, pretrig_len=4, ramp samples 0,1,2,…, trig_in on sample 20 -> trig_addr=4; frame order 16..31; out_last on 31; done one cycle later.
- pretrig_len=0, trig_in on the first sample (value 5) -> no PREFILL; first readout word 5; 16 consecutive words 5..20.
- pretrig_len=15 (DEPTH-1), trigger on sample 40 -> READOUT entered right after the trigger write; frame 25..40.
- Readout with out_ready pseudo-random (~50%) -> sequence identical to the out_ready=1 run; no drops or duplicates; with out_ready=1, words on consecutive clocks.
- abort during POSTFILL, then a fresh arm -> IDLE next clk, busy=0, no out_valid; the second capture completes correctly.
